// File: rtl/peg_l2_tx_arb_pkg.sv
// Shared types and constants for the MAC-TX packet arbiter.
package peg_l2_tx_arb_pkg;

   typedef enum logic {
      IDLE_S = 1'b0,
      GNT_S  = 1'b1
   } arb_state_e;

   localparam logic ARB_MODE_RR   = 1'b0;
   localparam logic ARB_MODE_PRIO = 1'b1;

   localparam int DROP_CNTR_W = 16;

endpackage

// File: rtl/peg_l2_rr_picker.sv
// Combinational winner select: round robin after last, or lowest index in priority mode.
// Zero latency; no flow control of its own.
module peg_l2_rr_picker
   import peg_l2_tx_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   input  logic               mode,
   output logic [IDX_W-1:0]   winner,
   output logic               any_req
);

   logic [NUM_REQ-1:0] rot;
   int                 start;
   int                 pos;

   always_comb begin
      start   = 0;
      pos     = 0;
      rot     = '0;
      any_req = 1'b0;
      // Priority mode is just round robin with the rotation pinned at zero.
      if (mode == ARB_MODE_RR) begin
         start = (int'(last) + 1) % NUM_REQ;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         rot[i] = req[(start + i) % NUM_REQ];
      end
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            pos     = i;
            any_req = 1'b1;
         end
      end
      winner = IDX_W'((start + pos) % NUM_REQ);
   end

endmodule

// File: rtl/peg_l2_tx_arb.sv
// Packet-granular arbiter feeding the RMII TX pkt_* port; grant locked SOP..accepted EOP.
// Mux path zero latency, one idle bubble per packet; pkt_ready passes straight to the granted source.
module peg_l2_tx_arb
   import peg_l2_tx_arb_pkg::*;
#(
   parameter int PKT_DATA_W = 8,
   parameter int PKT_SIZE_W = 16,
   parameter int NUM_REQ    = 4
) (
   input  logic                           rmii_ref_clk,
   input  logic                           rst,
   input  logic                           config_arb_mode,
   input  logic [NUM_REQ-1:0]             req_pkt_valid,
   input  logic [NUM_REQ-1:0]             req_pkt_sop,
   input  logic [NUM_REQ-1:0]             req_pkt_eop,
   input  logic [NUM_REQ-1:0]             req_pkt_error,
   input  logic [NUM_REQ*PKT_DATA_W-1:0]  req_pkt_data,
   input  logic [NUM_REQ*PKT_SIZE_W-1:0]  req_pkt_size,
   output logic [NUM_REQ-1:0]             req_pkt_ready,
   output logic                           pkt_valid,
   output logic                           pkt_sop,
   output logic                           pkt_eop,
   output logic                           pkt_error,
   output logic [PKT_DATA_W-1:0]          pkt_data,
   output logic [PKT_SIZE_W-1:0]          pkt_size,
   input  logic                           pkt_ready,
   output logic [NUM_REQ-1:0]             status_gnt_vec,
   output logic                           status_busy,
   output logic [DROP_CNTR_W-1:0]         status_drop_cntr
);

   localparam int IDX_W = $clog2(NUM_REQ);

   arb_state_e         state_f;
   arb_state_e         state_nxt;
   logic [IDX_W-1:0]   grant_f;
   logic [IDX_W-1:0]   last_gnt_f;
   logic [IDX_W-1:0]   winner;
   logic               any_req;
   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] orphan;
   logic               eop_xfer;

   assign elig     = req_pkt_valid & req_pkt_sop;
   assign orphan   = req_pkt_valid & ~req_pkt_sop;
   assign eop_xfer = (state_f == GNT_S) & pkt_valid & pkt_ready & pkt_eop;

   peg_l2_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req     (elig),
      .last    (last_gnt_f),
      .mode    (config_arb_mode),
      .winner  (winner),
      .any_req (any_req)
   );

   always_ff @(posedge rmii_ref_clk) begin
      if (rst) begin
         state_f <= IDLE_S;
      end else begin
         state_f <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state_f;
      case (state_f)
         IDLE_S:  if (any_req)  state_nxt = GNT_S;
         GNT_S:   if (eop_xfer) state_nxt = IDLE_S;
         default: state_nxt = IDLE_S;
      endcase
   end

   // last_gnt_f resets to the top index so requester 0 is first in line.
   always_ff @(posedge rmii_ref_clk) begin
      if (rst) begin
         grant_f          <= '0;
         last_gnt_f       <= IDX_W'(NUM_REQ - 1);
         status_drop_cntr <= '0;
      end else begin
         if (state_f == IDLE_S && any_req) begin
            grant_f <= winner;
         end
         if (eop_xfer) begin
            last_gnt_f <= grant_f;
         end
         if (state_f == IDLE_S && (|orphan) && (status_drop_cntr != '1)) begin
            status_drop_cntr <= status_drop_cntr + DROP_CNTR_W'(1);
         end
      end
   end

   always_comb begin
      req_pkt_ready  = '0;
      pkt_valid      = 1'b0;
      pkt_sop        = 1'b0;
      pkt_eop        = 1'b0;
      pkt_error      = 1'b0;
      pkt_data       = '0;
      pkt_size       = '0;
      status_gnt_vec = '0;
      status_busy    = 1'b0;
      if (!rst) begin
         if (state_f == IDLE_S) begin
            // Headless beats are swallowed so a broken source cannot wedge arbitration.
            req_pkt_ready = orphan;
         end else begin
            pkt_valid              = req_pkt_valid[grant_f];
            pkt_sop                = req_pkt_sop[grant_f];
            pkt_eop                = req_pkt_eop[grant_f];
            pkt_error              = req_pkt_error[grant_f];
            pkt_data               = req_pkt_data[int'(grant_f)*PKT_DATA_W +: PKT_DATA_W];
            pkt_size               = req_pkt_size[int'(grant_f)*PKT_SIZE_W +: PKT_SIZE_W];
            req_pkt_ready[grant_f] = pkt_ready;
            status_busy            = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
               status_gnt_vec[i] = (grant_f == IDX_W'(i));
            end
         end
      end
   end

endmodule

// File: doc/peg_l2_tx_arb.md
# peg_l2_tx_arb

Packet-granular arbiter that shares the single MAC-TX → RS (RMII TX) packet interface between up to NUM_REQ packet sources, e.g. the MAC data path, pause-frame generator and loopback/test source. It selects one requester per packet and locks the grant from SOP until the EOP beat is accepted downstream. Payload, size and error pass through a mux unchanged. It runs in the RMII reference clock domain and sits directly upstream of the RMII TX block's pkt_* inputs.

## Interface
- PKT_DATA_W, 8, packet data beat width
- PKT_SIZE_W, 16, packet size field width
- NUM_REQ, 4, number of requesters (2..8)
- rmii_ref_clk  in  1  sole clock, 50 MHz RMII reference
- rst  in  1  reset, synchronous, active-high
- config_arb_mode  in  1  0 = round robin, 1 = strict priority (lowest index wins)
- req_pkt_valid  in  NUM_REQ  per-requester beat valid
- req_pkt_sop  in  NUM_REQ  per-requester start of packet
- req_pkt_eop  in  NUM_REQ  per-requester end of packet
- req_pkt_error  in  NUM_REQ  per-requester error flag
- req_pkt_data  in  NUM_REQ*PKT_DATA_W  flattened data; requester i at [i*PKT_DATA_W +: PKT_DATA_W]
- req_pkt_size  in  NUM_REQ*PKT_SIZE_W  flattened size; same packing
- req_pkt_ready  out  NUM_REQ  per-requester ready
- pkt_valid, pkt_sop, pkt_eop, pkt_error  out  1 each  to RMII TX
- pkt_data  out  PKT_DATA_W  to RMII TX
- pkt_size  out  PKT_SIZE_W  to RMII TX
- pkt_ready  in  1  from RMII TX
- status_gnt_vec  out  NUM_REQ  one-hot current grant; 0 when idle
- status_busy  out  1  high in GNT_S
- status_drop_cntr  out  16  saturating count of cycles in which orphan beats were discarded

## Operation
- A beat transfers on a port when valid & ready are high in the same cycle.
- The FSM has two states, IDLE_S and GNT_S.
- IDLE_S:
  - pkt_valid = 0.
  - Eligible requesters are those with valid & sop.
  - If any requester is eligible, grant_f <= winner and the FSM moves to GNT_S next cycle. No ready is given to the winner in this cycle.
  - Orphan beats are requesters with valid & ~sop. Each gets req_pkt_ready = 1 and the beat is discarded.
  - status_drop_cntr increments by 1 in any cycle with at least one orphan and saturates at 16'hFFFF.
- GNT_S:
  - All pkt_* outputs = requester[grant_f] fields, combinationally.
  - req_pkt_ready[grant_f] = pkt_ready. All other readies = 0.
  - On pkt_valid & pkt_ready & pkt_eop: go to IDLE_S, and last_gnt_f <= grant_f.
- Round robin: search indices last_gnt_f+1 … last_gnt_f+NUM_REQ, modulo NUM_REQ. The first eligible index wins.
- Strict priority: the lowest eligible index wins. last_gnt_f is still updated.
- A config_arb_mode change takes effect at the next IDLE_S decision; it never affects an in-flight packet.
- SOP seen again mid-packet from the granted requester: passed through unchanged. The arbiter does not police framing within a grant.
- A granted requester that deasserts valid holds the grant indefinitely. There is no timeout.
- pkt_error is passed through only; it does not release the grant.

## Timing
- Reset values: fsm IDLE_S, grant_f 0, last_gnt_f NUM_REQ-1 (so requester 0 wins first), status_drop_cntr 0.
- While rst is high: all req_pkt_ready = 0, pkt_valid = 0, status_gnt_vec = 0, status_busy = 0.
- Reset mid-packet: the grant is dropped on the next edge. The partial packet is not completed and its remaining beats later arrive as orphans.
- Grant latency: the first valid & sop in IDLE_S is seen at edge N, and pkt_valid is high from cycle N+1.
- Mux path: pkt_* and req_pkt_ready are combinational from grant_f. There is no pipeline stage, so the data path has zero latency.
- Packet gap: exactly one IDLE_S bubble cycle after each EOP transfer. Back-to-back packets therefore cost 1 cycle.
- Equal EOP and new SOP in the same cycle: the new request is evaluated in the following IDLE_S cycle.
- status_gnt_vec and status_busy are decoded from registered state (glitch-free).

## Structure
- Package peg_l2_tx_arb_pkg holds:
  - FSM state enum (IDLE_S = 1'b0, GNT_S = 1'b1)
  - ARB_MODE_RR = 1'b0 and ARB_MODE_PRIO = 1'b1
  - the DROP_CNTR_W = 16 constant
- One sub-module, peg_l2_rr_picker: purely combinational.
  - Inputs: req vector, last pointer, mode.
  - Outputs: winner index and any-request flag.
  - Rotate, priority-encode, un-rotate.

## Test plan
- Reset, then req0 and req2 both present SOP with 3-beat packets, RR mode -> req0 is granted at cycle 1 and its 3 beats pass through, then 1 idle cycle, then req2 is granted.
- RR mode, all 4 requesters continuously requesting 1-beat packets -> grant order is 0,1,2,3,0. status_gnt_vec reads 0001, 0010, 0100, 1000.
- Strict mode, req3 and req1 continuously requesting -> req1 is granted every time; req3 is never granted until req1 goes idle.
- Granted req1 sends a 60-beat packet; pkt_ready toggles 1/0, and req0 raises SOP mid-packet -> req1's beats arrive in order, req0 sees ready = 0 throughout, and the grant moves to req0 only after req1's EOP is accepted.
- In IDLE_S, req2 drives valid=1, sop=0 for 5 cycles -> req_pkt_ready[2] = 1 for those cycles, pkt_valid = 0, status_drop_cntr = 5. Forcing the counter to 16'hFFFF plus one more orphan cycle leaves it at 16'hFFFF.
- rst asserted at beat 10 of a 20-beat packet -> the next cycle is IDLE_S, all readies are 0 while rst is high, and after release req0 (last pointer 3) wins the next arbitration.
